// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/busy/done handshake plus operand and result buses
interface serial_subtractor_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    modport master (output start, a, b, input busy, done, diff, borrow);
    modport slave (input start, a, b, output busy, done, diff, borrow);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial LSB-first a - b with registered borrow and start/busy/done handshake
module serial_subtractor #(parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    serial_subtractor_if.slave bus
);
    localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] ra, rb, res, res_n, diff_q;
    logic [WIDTH:0] ext;
    logic [CW-1:0] cnt;
    logic br, br_n, d, borrow_q, accept, last;
    always_comb begin
        accept = bus.start && state != SHIFT;
        last = cnt == CW'(WIDTH - 1);
        d = ra[0] ^ rb[0] ^ br;
        br_n = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        ext = {d, res};
        res_n = ext[WIDTH:1];
        state_n = state == SHIFT ? (last ? DONE : SHIFT) : (accept ? SHIFT : IDLE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ra <= '0;
            rb <= '0;
            res <= '0;
            br <= 1'b0;
            cnt <= '0;
            diff_q <= '0;
            borrow_q <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                ra <= bus.a;
                rb <= bus.b;
                br <= 1'b0;
                cnt <= '0;
            end else if (state == SHIFT) begin
                ra <= ra >> 1;
                rb <= rb >> 1;
                br <= br_n;
                cnt <= cnt + CW'(1);
                res <= res_n;
                if (last) begin
                    diff_q <= res_n;
                    borrow_q <= br_n;
                end
            end
        end
    end
    assign bus.busy = state == SHIFT;
    assign bus.done = state == DONE;
    assign bus.diff = diff_q;
    assign bus.borrow = borrow_q;
endmodule
